loctag_adc_sampler: RTL
=======================

// Module: loctag_adc_sampler
// PURPOSE
// Parametrised serial-ADC frame controller for the LocTag detector path. Drives the ADC CS/SCLK, shifts in SO MSB-first,
// extracts the data field and hands samples out over a valid/ready handshake. Supports single-shot (trigger) and
// continuous modes. Replaces the free-running CS/clock tie-off used on the test board.
// PARAMETERS
// CLK_DIV     2   SCLK half-period in clk cycles (>=2)
// FRAME_BITS  16  SCLK cycles per CS-low frame (>=2)
// DATA_BITS   12  width of extracted sample
// DATA_LSB    0   LSB position of sample in frame; DATA_LSB+DATA_BITS <= FRAME_BITS
// QUIET_CYC   4   CS-high clk cycles between frames (>=1)
// PORTS
// clk          in   1          system clock
// reset        in   1          synchronous, active-high reset
// enable       in   1          0: no new frames start; a frame in progress completes
// mode         in   1          0 single-shot, 1 continuous; sampled only in IDLE/QUIET
// start        in   1          single-shot request pulse; accepted only in IDLE with enable=1, mode=0
// adc_cs       out  1          ADC chip select, active low
// adc_sclk     out  1          ADC serial clock, idles low
// adc_so       in   1          ADC serial data; registered once inside block
// sample_data  out  DATA_BITS  frame[DATA_LSB +: DATA_BITS], unsigned
// sample_valid out  1          sample_data valid; held until sample_valid&&sample_ready
// sample_ready in   1          consumer accepts sample
// overrun      out  1          sticky: completed frame dropped because output still held
// overrun_clr  in   1          clears overrun
// busy         out  1          high in SETUP/SHIFT/QUIET
// frame_count  out  16         completed frames, wraps 0xFFFF->0
// thresh       in   DATA_BITS  detect threshold (LOCTAG_ADC_THRESH_EN only)
// detect       out  1          threshold hit pulse (LOCTAG_ADC_THRESH_EN only)
// BEHAVIOUR
// - Reset: adc_cs=1, adc_sclk=0, sample_valid=0, sample_data=0, overrun=0, busy=0, frame_count=0, detect=0, state=IDLE.
//   Reset mid-frame aborts: CS high, SCLK low on the next edge. Partial data is discarded.
// - FSM: IDLE -> SETUP -> SHIFT -> QUIET -> (IDLE | SETUP).
//   IDLE->SETUP when enable && (mode ? 1 : start). CS falls on the first cycle after the cycle start was accepted.
//   SETUP: CS=0, SCLK=0, lasts CLK_DIV cycles.
//   SHIFT: SCLK toggles every CLK_DIV cycles, 2*FRAME_BITS half-periods, starting low->high.
//     On each low->high toggle edge, the registered adc_so shifts into frame[0]; earlier bits move toward the MSB.
//   After the last high half-period: SCLK=0, CS=1, enter QUIET.
//   In the same cycle, the frame completes: frame_count increments and the sample is offered.
//   QUIET: CS=1 for QUIET_CYC cycles, then SETUP if enable && mode, else IDLE. Mode and enable are sampled on the last QUIET cycle.
// - Latency, start accepted at cycle 0: sample_valid rises at cycle 1+CLK_DIV*(1+2*FRAME_BITS).
// - Continuous frame period: CLK_DIV*(1+2*FRAME_BITS)+QUIET_CYC cycles.
// - start while busy, or with mode=1, is ignored. A start pulse is not queued.
// - Handshake, on frame completion:
//   - if !sample_valid || sample_ready: load the new sample; sample_valid=1.
//   - else: keep the old data and set overrun.
//   sample_valid && sample_ready with no completion -> sample_valid=0 next cycle.
// - overrun: if set and overrun_clr occur in the same cycle, set wins.
// - enable falling mid-frame: the frame finishes normally, including QUIET, then goes to IDLE.
// CONFIGURATION
// - LOCTAG_ADC_THRESH_EN defined:
//   - at every frame completion, dropped or not, detect pulses high for 1 cycle iff extracted value >= thresh (unsigned);
//   - the detect pulse coincides with the completion cycle.
//   - thresh is sampled in the completion cycle.
// - LOCTAG_ADC_THRESH_EN undefined: thresh is ignored; detect is constant 0. The port list is unchanged.
// TESTING (defaults unless noted)
// - Single-shot: mode=0, start pulse at cycle 0, SO pattern 0x0ABC -> CS low cycles 1..66, 16 SCLK rising edges,
//   sample_valid at cycle 67 with sample_data=0xABC, frame_count=1.
// - Continuous: mode=1, enable=1, ready=1 -> CS falls every 70 cycles; 5 frames give frame_count=5 and 5 handshakes.
// - Back-pressure: ready=0 across 2 frames -> first sample held, overrun=1 at second completion.
//   overrun_clr in the same cycle as the second completion -> overrun still 1. overrun_clr next cycle -> overrun 0.
// - Reset mid-SHIFT, at the 8th SCLK rise -> next cycle CS=1, SCLK=0, valid=0, count=0.
//   Fresh start -> correct new sample.
// - enable dropped mid-frame, continuous -> that frame completes and is delivered, CS stays high afterwards, busy=0.
// - THRESH_EN, thresh=0x800: sample 0x7FF -> detect=0; sample 0x800 -> detect 1-cycle pulse coincident with completion.

Source files
------------

// File: rtl/loctag_adc_sampler.sv
// loctag_adc_sampler: serial-ADC frame controller (CS/SCLK drive, MSB-first capture, valid/ready out).
// Define LOCTAG_ADC_THRESH_EN to enable the threshold detect pulse on frame completion.
module loctag_adc_sampler #(
    parameter int CLK_DIV    = 2,
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int DATA_LSB   = 0,
    parameter int QUIET_CYC  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 mode,
    input  logic                 start,
    output logic                 adc_cs,
    output logic                 adc_sclk,
    input  logic                 adc_so,
    output logic [DATA_BITS-1:0] sample_data,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 busy,
    output logic [15:0]          frame_count,
    input  logic [DATA_BITS-1:0] thresh,
    output logic                 detect
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        QUIET
    } state_t;

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] QUIET_LAST = 16'(QUIET_CYC - 1);
    localparam logic [15:0] HALF_LAST  = 16'(2 * FRAME_BITS - 1);

    state_t                state;
    logic [15:0]           cnt;
    logic [15:0]           half;
    logic                  so_q;
    logic [FRAME_BITS-1:0] frame;
    logic [DATA_BITS-1:0]  field;
    logic                  frame_done;
    logic                  take;
    logic                  unused_frame_msb;

    assign field            = frame[DATA_LSB +: DATA_BITS];
    assign unused_frame_msb = frame[FRAME_BITS-1];
    assign take             = !sample_valid || sample_ready;

    // The last high half-period expiring is the completion edge.
    assign frame_done = (state == SHIFT) && (cnt == DIV_LAST)
                        && (half == HALF_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            half         <= '0;
            so_q         <= 1'b0;
            frame        <= '0;
            adc_cs       <= 1'b1;
            adc_sclk     <= 1'b0;
            busy         <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            frame_count  <= '0;
        end else begin
            so_q <= adc_so;

            if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (overrun_clr) begin
                overrun <= 1'b0;
            end
            // Later assignments win: a completion overrides clear/handshake.
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
                if (take) begin
                    sample_data  <= field;
                    sample_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (enable && (mode || start)) begin
                        state  <= SETUP;
                        adc_cs <= 1'b0;
                        busy   <= 1'b1;
                        cnt    <= '0;
                    end
                end
                SETUP: begin
                    if (cnt == DIV_LAST) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        half  <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (half == HALF_LAST) begin
                            state    <= QUIET;
                            adc_cs   <= 1'b1;
                            adc_sclk <= 1'b0;
                        end else begin
                            half     <= half + 16'd1;
                            adc_sclk <= ~adc_sclk;
                            if (!adc_sclk) begin
                                frame <= {frame[FRAME_BITS-2:0], so_q};
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                QUIET: begin
                    if (cnt == QUIET_LAST) begin
                        cnt <= '0;
                        if (enable && mode) begin
                            state  <= SETUP;
                            adc_cs <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LOCTAG_ADC_THRESH_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            detect <= 1'b0;
        end else begin
            detect <= frame_done && (field >= thresh);
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign detect        = 1'b0;
`endif

endmodule
